// File: rtl/sfx_arbiter.sv
// sfx_arbiter: time-shares the tone path between background music and four prioritized one-shot sound effects.
module sfx_arbiter #(
  parameter int SFX_LEN   = 8,
  parameter int GAP_BEATS = 1,
  parameter int PREEMPT   = 1,
  parameter int SILENCE   = 20000,
  parameter int BGM_VOL   = 2,
  parameter int SFX_VOL   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        beat_tick,
  input  logic [3:0]  req,
  input  logic [31:0] bgm_freqL,
  input  logic [31:0] bgm_freqR,
  output logic [31:0] freqL,
  output logic [31:0] freqR,
  output logic [2:0]  volume,
  output logic        busy,
  output logic [1:0]  sfx_id,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;
  state_e state_q, state_d;
  logic [3:0] pend_q, pend_d, clr;
  logic [2:0] step_q, step_d, vol_d;
  logic [7:0] gap_q, gap_d;
  logic [1:0] id_q, id_d, top;
  logic [31:0] fl_d, fr_d, tone;
  logic done_q, done_d, any, pre, last, gnt;

  function automatic logic [31:0] rom(input logic [1:0] id, input logic [2:0] s);
    logic [31:0] r;
    case (id)
      2'd0: r = s[0] ? 32'd784 : 32'd1047;
      2'd1: case (s)
        3'd0: r = 32'd523;
        3'd1: r = 32'd587;
        3'd2: r = 32'd659;
        3'd3: r = 32'd698;
        3'd4: r = 32'd784;
        3'd5: r = 32'd880;
        3'd6: r = 32'd988;
        default: r = 32'd1047;
      endcase
      2'd2: r = s[2] ? 32'(SILENCE) : 32'd262;
      default: r = s[2] ? 32'd440 : 32'd880;
    endcase
    return r;
  endfunction

  assign any  = |pend_q;
  assign top  = pend_q[0] ? 2'd0 : pend_q[1] ? 2'd1 : pend_q[2] ? 2'd2 : 2'd3;
  assign pre  = (PREEMPT != 0) && any && (top < id_q);
  assign last = step_q == 3'(SFX_LEN - 1);

  // Preemption is checked ahead of end-of-effect so a cut effect never reports done.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    gap_d   = gap_q;
    id_d    = id_q;
    clr     = '0;
    done_d  = 1'b0;
    gnt     = 1'b0;
    if (beat_tick) begin
      case (state_q)
        IDLE: gnt = any;
        PLAY: begin
          if (pre) gnt = 1'b1;
          else if (!last) step_d = step_q + 3'd1;
          else begin
            done_d = 1'b1;
            gap_d  = '0;
            if (GAP_BEATS == 0) begin
              gnt     = any;
              state_d = IDLE;
            end else state_d = GAP;
          end
        end
        GAP: begin
          if (gap_q == 8'(GAP_BEATS - 1)) begin
            gnt     = any;
            state_d = IDLE;
          end else gap_d = gap_q + 8'd1;
        end
        default: state_d = IDLE;
      endcase
    end
    if (gnt) begin
      state_d = PLAY;
      id_d    = top;
      step_d  = '0;
      clr     = 4'b1 << top;
    end
    pend_d = (pend_q & ~clr) | req;
    tone   = rom(id_d, step_d);
    fl_d   = state_d == PLAY ? tone : state_d == GAP ? 32'(SILENCE) : bgm_freqL;
    fr_d   = state_d == PLAY ? tone : state_d == GAP ? 32'(SILENCE) : bgm_freqR;
    vol_d  = state_d == IDLE ? 3'(BGM_VOL) : 3'(SFX_VOL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      step_q  <= '0;
      gap_q   <= '0;
      id_q    <= '0;
      freqL   <= 32'(SILENCE);
      freqR   <= 32'(SILENCE);
      volume  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      step_q  <= step_d;
      gap_q   <= gap_d;
      id_q    <= id_d;
      freqL   <= fl_d;
      freqR   <= fr_d;
      volume  <= vol_d;
      done_q  <= done_d;
    end
  end

  assign busy   = state_q != IDLE;
  assign sfx_id = id_q;
  assign done   = done_q;
endmodule

// File: tb/tb_sfx_arbiter.sv
// tb_sfx_arbiter: vector table, directed corner sequences and randomized traffic against a beat-level reference model.
module tb_sfx_arbiter;
  localparam int SIL = 20000;
  logic clk = 0, rst = 1, beat_tick = 0;
  logic [3:0] req = 0;
  logic [31:0] bgm_freqL = 0, bgm_freqR = 0;
  logic [31:0] fl0, fr0, fl1, fr1;
  logic [2:0] vol0, vol1;
  logic busy0, busy1, done0, done1;
  logic [1:0] id0, id1;
  int checks = 0, failures = 0;

  sfx_arbiter #(.PREEMPT(1)) u0 (.clk(clk), .rst(rst), .beat_tick(beat_tick), .req(req),
    .bgm_freqL(bgm_freqL), .bgm_freqR(bgm_freqR), .freqL(fl0), .freqR(fr0), .volume(vol0),
    .busy(busy0), .sfx_id(id0), .done(done0));
  sfx_arbiter #(.PREEMPT(0)) u1 (.clk(clk), .rst(rst), .beat_tick(beat_tick), .req(req),
    .bgm_freqL(bgm_freqL), .bgm_freqR(bgm_freqR), .freqL(fl1), .freqR(fr1), .volume(vol1),
    .busy(busy1), .sfx_id(id1), .done(done1));

  always #5 clk = ~clk;

  int tbl [4][8] = '{'{1047, 784, 1047, 784, 1047, 784, 1047, 784},
                     '{523, 587, 659, 698, 784, 880, 988, 1047},
                     '{262, 262, 262, 262, SIL, SIL, SIL, SIL},
                     '{880, 880, 880, 880, 440, 440, 440, 440}};

  // Reference: cur = effect playing (-1 none), pos = beat within effect, gap = silent beats still owed.
  int m_cur[2], m_pos[2], m_gap[2], m_id[2];
  bit [3:0] m_pend[2];
  bit m_done[2], m_rst[2];

  function automatic int lowest(bit [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i]) return i;
    return -1;
  endfunction

  task automatic start(int k, int e);
    m_cur[k] = e; m_pos[k] = 0; m_gap[k] = 0; m_id[k] = e; m_pend[k][e] = 1'b0;
  endtask

  task automatic model(int k, bit pre);
    int lo;
    lo = lowest(m_pend[k]);
    m_done[k] = 0;
    m_rst[k] = rst;
    if (rst) begin
      m_cur[k] = -1; m_pos[k] = 0; m_gap[k] = 0; m_id[k] = 0; m_pend[k] = 0;
    end else begin
      if (beat_tick) begin
        if (m_cur[k] >= 0 && m_gap[k] == 0) begin
          if (pre && lo >= 0 && lo < m_cur[k]) start(k, lo);
          else if (m_pos[k] < 7) m_pos[k]++;
          else begin
            m_done[k] = 1; m_gap[k] = 1;
          end
        end else if (m_gap[k] > 0) begin
          m_gap[k]--;
          if (lo >= 0) start(k, lo); else m_cur[k] = -1;
        end else if (lo >= 0) start(k, lo);
      end
      m_pend[k] |= req;
    end
  endtask

  task automatic cmp(int k);
    logic [31:0] afl, afr, efl, efr;
    logic [2:0] avol, evol;
    logic ab, ad, eb;
    logic [1:0] aid;
    afl = k ? fl1 : fl0; afr = k ? fr1 : fr0; avol = k ? vol1 : vol0;
    ab = k ? busy1 : busy0; ad = k ? done1 : done0; aid = k ? id1 : id0;
    eb = m_cur[k] >= 0;
    if (m_rst[k]) begin
      efl = SIL; efr = SIL; evol = 0;
    end else if (eb) begin
      efl = m_gap[k] > 0 ? SIL : tbl[m_cur[k]][m_pos[k]]; efr = efl; evol = 4;
    end else begin
      efl = bgm_freqL; efr = bgm_freqR; evol = 2;
    end
    checks++;
    if (afl !== efl || afr !== efr || avol !== evol || ab !== eb || ad !== m_done[k] || aid !== 2'(m_id[k])) begin
      failures++;
      $display("FAIL model dut%0d t=%0t got fl=%0d fr=%0d vol=%0d busy=%0d id=%0d done=%0d want fl=%0d fr=%0d vol=%0d busy=%0d id=%0d done=%0d",
        k, $time, afl, afr, avol, ab, aid, ad, efl, efr, evol, eb, m_id[k], m_done[k]);
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(bit r, bit t, logic [3:0] q, logic [31:0] bl, logic [31:0] br);
    rst = r; beat_tick = t; req = q; bgm_freqL = bl; bgm_freqR = br;
    @(posedge clk); #1;
    model(0, 1); model(1, 0); cmp(0); cmp(1);
  endtask

  task automatic tk(); cyc(0, 0, 0, 440, 440); cyc(0, 1, 0, 440, 440); endtask

  typedef struct {bit r; bit t; logic [3:0] q; logic [31:0] fl; logic [2:0] vol; bit busy; logic [1:0] id; bit done;} vec_t;
  vec_t vt[$];

  initial begin
    int seen3, d0, d1, bad;
    bit pt;
    vt.push_back('{1, 0, 4'b0000, SIL, 0, 0, 0, 0});
    vt.push_back('{0, 0, 4'b0000, 440, 2, 0, 0, 0});
    vt.push_back('{0, 0, 4'b0010, 440, 2, 0, 0, 0});
    vt.push_back('{0, 1, 4'b0000, 523, 4, 1, 1, 0});
    foreach (tbl[1][s]) if (s > 0) vt.push_back('{0, 1, 4'b0000, 32'(tbl[1][s]), 4, 1, 1, 0});
    vt.push_back('{0, 1, 4'b0000, SIL, 4, 1, 1, 1});
    vt.push_back('{0, 1, 4'b0000, 440, 2, 0, 1, 0});
    foreach (vt[i]) begin
      cyc(vt[i].r, vt[i].t, vt[i].q, 440, 440);
      chk($sformatf("vec%0d.freqL", i), fl0, vt[i].fl);
      chk($sformatf("vec%0d.vol", i), {29'd0, vol0}, {29'd0, vt[i].vol});
      chk($sformatf("vec%0d.busy_id_done", i), {28'd0, busy0, id0, done0}, {28'd0, vt[i].busy, vt[i].id, vt[i].done});
      cyc(0, 0, 0, 440, 440);
    end
    // Simultaneous requests: sfx2 first, then sfx3 straight out of the gap.
    cyc(0, 0, 4'b1100, 440, 440);
    tk();
    chk("dual.first_tone", fl0, 262);
    chk("dual.first_id", {30'd0, id0}, 2);
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(0, 0, 0, 440, 440); if (!busy0) bad++;
      cyc(0, 1, 0, 440, 440); if (!busy0) bad++;
    end
    chk("dual.no_bgm_between", bad, 0);
    chk("dual.second_tone", fl0, 880);
    chk("dual.second_id", {30'd0, id0}, 3);
    // Preempt sfx3 at step 5 with sfx0.
    repeat (5) tk();
    chk("pre.step5", fl0, 440);
    cyc(0, 0, 4'b0001, 440, 440);
    cyc(0, 1, 0, 440, 440);
    chk("pre.tone", fl0, 1047);
    chk("pre.id", {30'd0, id0}, 0);
    chk("pre.no_done", {31'd0, done0}, 0);
    chk("nopre.keeps", {30'd0, id1}, 3);
    seen3 = 0; d0 = 0; d1 = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(0, 0, 0, 440, 440); d0 += done0; d1 += done1; if (busy0 && id0 == 3) seen3++;
      cyc(0, 1, 0, 440, 440); d0 += done0; d1 += done1; if (busy0 && id0 == 3) seen3++;
    end
    chk("pre.never_resumes", seen3, 0);
    chk("pre.done_count", d0, 1);
    chk("nopre.done_count", d1, 2);
    // Reset mid-effect with another request pending.
    cyc(0, 0, 4'b0010, 440, 440);
    tk(); tk();
    cyc(0, 0, 4'b0100, 440, 440);
    cyc(1, 0, 0, 440, 440);
    chk("rst.freqL", fl0, SIL);
    chk("rst.busy", {31'd0, busy0}, 0);
    chk("rst.vol", {29'd0, vol0}, 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tk(); if (busy0 || busy1) bad++;
    end
    chk("rst.pending_dropped", bad, 0);
    // Randomized traffic; ticks are always isolated single-cycle pulses.
    pt = 0;
    for (int i = 0; i < 4000; i++) begin
      bit t, r;
      logic [3:0] q;
      t = !pt && ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 299) == 0;
      q = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0;
      cyc(r, t, q, 32'($urandom_range(100, 2000)), 32'($urandom_range(100, 2000)));
      pt = t;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
